windowed_watchdog: RTL and testbench
====================================

Name: windowed_watchdog

Overview:
Parametrised windowed watchdog, the next generation of the team's single-timeout watchdog. It adds a programmable timeout, an early-warning stage, a kick window (kicks that arrive too early are faults), a stretched reset pulse, an optional enable lock and sticky cause reporting. It sits beside the system controller: software or an FSM kicks it, and `wdt_reset` drives the chip reset generator.

Parameters:
CNT_W, 16, width of the cycle counter and of all threshold inputs
RST_PULSE, 4, number of cycles `wdt_reset` stays high per bite (must be 1 or more)
WINDOW_EN, 1, 1 = an early kick is a fault; 0 = a kick is accepted at any count
LOCK_EN, 0, 1 = once armed, `enable` deassertion is ignored until `rst_n`

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  arm the watchdog; level-sensitive
kick  in  1  service pulse; sampled each cycle, one cycle = one kick
timeout_val  in  CNT_W  cycles from last kick to bite; 0 means 2^CNT_W
warn_val  in  CNT_W  count at which the warning is raised
window_open  in  CNT_W  earliest count at which a kick is legal
wdt_warn  out  1  high in WARN state
wdt_reset  out  1  reset pulse, RST_PULSE cycles wide
cause_timeout  out  1  sticky: at least one bite caused by timeout
cause_early  out  1  sticky: at least one bite caused by an early kick
bite_count  out  8  number of bites, saturates at 255
count  out  CNT_W  current counter value, for debug

Behaviour:
- Reset (`rst_n`=0, asynchronous): state IDLE; `count`=0; all outputs 0; sticky flags and `bite_count` cleared. Only `rst_n` clears the sticky flags and `bite_count`.
- States: IDLE, RUN, WARN, BITE.
- Configuration:
  - `timeout_val`, `warn_val` and `window_open` are latched into shadow registers on the IDLE->RUN transition.
  - They are also re-latched on each BITE->RUN transition.
  - Changes while in RUN or WARN have no effect.
- IDLE:
  - `count` holds 0.
  - `enable`=1 -> RUN on the next edge, with `count`=0.
  - A kick in IDLE is ignored.
- RUN / WARN, each edge (priority top to bottom):
  1. `enable`=0 and (LOCK_EN=0 or not yet armed) -> IDLE, `count`=0. With LOCK_EN=1 an "armed" flag is set on leaving IDLE and cleared only by `rst_n`.
  2. `kick`=1 and WINDOW_EN=1 and `count` < `window_open` -> BITE, set `cause_early`.
  3. `kick`=1 (legal) -> RUN, `count`=0; `wdt_warn` drops on the same edge.
  4. (`count`+1) truncated to CNT_W equals shadow `timeout_val` -> BITE, set `cause_timeout`. Wrap of all-ones+1 to 0 makes `timeout_val`=0 mean 2^CNT_W.
  5. (`count`+1) equals `warn_val` and state is RUN -> WARN, `count`+1.
  6. Otherwise `count`+1.
- Consequences of the priority order:
  - A kick at the exact timeout cycle (`count`=timeout-1) is legal and wins over timeout.
  - If `warn_val` >= `timeout_val`, or `warn_val` is 0, WARN is never entered.
  - If `window_open` > `count` at timeout, the fault becomes a timeout bite, not an early one.
- BITE:
  - `wdt_reset`=1 for exactly RST_PULSE cycles, counted by a pulse counter.
  - `bite_count` increments once on entry (saturating).
  - `count` is held at 0 and kicks are ignored.
  - After the pulse: -> RUN if `enable`=1 (or armed under LOCK_EN), else -> IDLE.
  - `wdt_warn`=0 in BITE.
- All outputs are registered; `wdt_warn` and `wdt_reset` reflect the state with no combinational path from inputs.
- Latency:
  - Bite on timeout: `wdt_reset` rises T cycles after the last legal kick edge, where T = `timeout_val`.
  - Early kick: `wdt_reset` rises on the edge that samples the kick.

Decomposition:
- Package `wdt_pkg`:
  - state enum (IDLE=2'd0, RUN=2'd1, WARN=2'd2, BITE=2'd3);
  - cause encoding constants;
  - `bite_count` width constant (8).
- One sub-module, `wdt_pulse_stretch`: loadable down-counter that generates the RST_PULSE-wide `wdt_reset` and a done strobe.
- FSM, counter, shadow registers and sticky flags live in the top level.

Test Plan:
1. CNT_W=8, timeout=20, warn=15, window=5; enable, then kick every 10 cycles for 100 cycles -> `wdt_reset` never asserts, `wdt_warn` never asserts, `count` peaks at 9.
2. Same config, stop kicking -> `wdt_warn` rises when `count`=15; `wdt_reset` high for 4 cycles starting 20 cycles after the last kick; `cause_timeout`=1, `bite_count`=1, then back in RUN with `count`=0.
3. Kick at `count`=3 (below window 5) -> immediate BITE; `cause_early`=1, `cause_timeout` stays 0. Kick at `count`=5 -> accepted.
4. Kick exactly at `count`=19 -> no bite and `count`=0; kick during BITE -> ignored, pulse still exactly 4 cycles.
5. LOCK_EN=1: deassert `enable` in RUN -> still times out at 20; with LOCK_EN=0 -> IDLE, `count`=0, no bite. Change `timeout_val` to 50 mid-run -> the bite still occurs at 20.
6. Assert `rst_n` low mid-BITE -> `wdt_reset` falls immediately, flags and `bite_count` are 0, state is IDLE. Separately, `timeout_val`=0 with CNT_W=8 -> bite after 256 cycles.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the windowed watchdog.
package wdt_pkg;

   // Watchdog FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WARN = 2'd2,
      BITE = 2'd3
   } wdt_state_e;

   // Cause of a bite, decided on the edge that enters BITE
   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
   localparam logic [1:0] CAUSE_EARLY   = 2'd2;

   localparam int BITE_CNT_W = 8;
   localparam logic [BITE_CNT_W-1:0] BITE_CNT_MAX = 8'hFF;

   // Saturating increment for the bite counter
   function automatic logic [BITE_CNT_W-1:0] bite_sat_inc(input logic [BITE_CNT_W-1:0] v);
      if (v == BITE_CNT_MAX) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/wdt_pulse_stretch.sv
// Loadable down-counter producing a RST_PULSE-cycle reset pulse.
// 'done' is high during the last cycle of the pulse.
module wdt_pulse_stretch #(
   parameter int RST_PULSE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic pulse,
   output logic done
);

   localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
   localparam logic [PW-1:0] LOAD_VAL = PW'(RST_PULSE - 1);

   logic [PW-1:0] remain_r;
   logic          pulse_r;

   // Load on bite entry, then count the remaining pulse cycles down to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remain_r <= '0;
         pulse_r  <= 1'b0;
      end else if (load) begin
         remain_r <= LOAD_VAL;
         pulse_r  <= 1'b1;
      end else if (pulse_r) begin
         if (remain_r == '0) begin
            pulse_r <= 1'b0;
         end else begin
            remain_r <= remain_r - PW'(1);
         end
      end
   end

   assign pulse = pulse_r;
   assign done  = pulse_r && (remain_r == '0);

endmodule

// File: rtl/windowed_watchdog.sv
// Windowed watchdog: programmable timeout, warning stage, kick window,
// stretched reset pulse, optional enable lock and sticky cause flags.
module windowed_watchdog
   import wdt_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int RST_PULSE = 4,
   parameter int WINDOW_EN = 1,
   parameter int LOCK_EN   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             kick,
   input  logic [CNT_W-1:0] timeout_val,
   input  logic [CNT_W-1:0] warn_val,
   input  logic [CNT_W-1:0] window_open,
   output logic             wdt_warn,
   output logic             wdt_reset,
   output logic             cause_timeout,
   output logic             cause_early,
   output logic [7:0]       bite_count,
   output logic [CNT_W-1:0] count
);

   wdt_state_e            state_r;
   wdt_state_e            next_state_s;
   logic [CNT_W-1:0]      count_r;
   logic [CNT_W-1:0]      next_count_s;
   logic [CNT_W-1:0]      count_inc_s;
   logic [CNT_W-1:0]      tmo_r;
   logic [CNT_W-1:0]      warn_lvl_r;
   logic [CNT_W-1:0]      win_r;
   logic                  armed_r;
   logic                  warn_r;
   logic                  cause_timeout_r;
   logic                  cause_early_r;
   logic [BITE_CNT_W-1:0] bite_count_r;
   logic [1:0]            cause_s;
   logic                  latch_s;
   logic                  keep_armed_s;
   logic                  early_s;
   logic                  bite_load_s;
   logic                  pulse_done_s;

   // Truncating increment makes a zero timeout mean a full 2^CNT_W cycles
   assign count_inc_s  = count_r + CNT_W'(1);
   assign keep_armed_s = (LOCK_EN != 0) && armed_r;
   assign early_s      = kick && (WINDOW_EN != 0) && (count_r < win_r);
   assign bite_load_s  = (cause_s != CAUSE_NONE);

   // Next-state, next-count and bite-cause decision in priority order
   always_comb begin
      next_state_s = state_r;
      next_count_s = count_r;
      cause_s      = CAUSE_NONE;
      latch_s      = 1'b0;
      case (state_r)
         IDLE: begin
            next_count_s = '0;
            if (enable) begin
               next_state_s = RUN;
               latch_s      = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN, WARN: begin
            if (!enable && !keep_armed_s) begin
               next_state_s = IDLE;
               next_count_s = '0;
            end else if (early_s) begin
               next_state_s = BITE;
               next_count_s = '0;
               cause_s      = CAUSE_EARLY;
            end else if (kick) begin
               next_state_s = RUN;
               next_count_s = '0;
            end else if (count_inc_s == tmo_r) begin
               next_state_s = BITE;
               next_count_s = '0;
               cause_s      = CAUSE_TIMEOUT;
            end else if ((count_inc_s == warn_lvl_r) && (state_r == RUN)) begin
               next_state_s = WARN;
               next_count_s = count_inc_s;
            end else begin
               next_state_s = state_r;
               next_count_s = count_inc_s;
            end
         end
         BITE: begin
            next_count_s = '0;
            if (pulse_done_s) begin
               if (enable || keep_armed_s) begin
                  next_state_s = RUN;
                  latch_s      = 1'b1;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_state_s = BITE;
            end
         end
         default: begin
            next_state_s = IDLE;
            next_count_s = '0;
         end
      endcase
   end

   // State, counter, shadow configuration, lock and sticky status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= IDLE;
         count_r         <= '0;
         tmo_r           <= '0;
         warn_lvl_r      <= '0;
         win_r           <= '0;
         armed_r         <= 1'b0;
         warn_r          <= 1'b0;
         cause_timeout_r <= 1'b0;
         cause_early_r   <= 1'b0;
         bite_count_r    <= '0;
      end else begin
         state_r <= next_state_s;
         count_r <= next_count_s;
         warn_r  <= (next_state_s == WARN);
         if (latch_s) begin
            tmo_r      <= timeout_val;
            warn_lvl_r <= warn_val;
            win_r      <= window_open;
         end
         if ((state_r == IDLE) && (next_state_s != IDLE)) begin
            armed_r <= 1'b1;
         end
         if (cause_s == CAUSE_TIMEOUT) begin
            cause_timeout_r <= 1'b1;
         end
         if (cause_s == CAUSE_EARLY) begin
            cause_early_r <= 1'b1;
         end
         if (bite_load_s) begin
            bite_count_r <= bite_sat_inc(bite_count_r);
         end
      end
   end

   wdt_pulse_stretch #(
      .RST_PULSE (RST_PULSE)
   ) u_pulse (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (bite_load_s),
      .pulse (wdt_reset),
      .done  (pulse_done_s)
   );

   assign wdt_warn      = warn_r;
   assign cause_timeout = cause_timeout_r;
   assign cause_early   = cause_early_r;
   assign bite_count    = bite_count_r;
   assign count         = count_r;

endmodule

// File: tb/tb_windowed_watchdog.sv
// Randomised bench for windowed_watchdog: two instances (LOCK_EN 0 and 1)
// share stimulus and are compared every cycle against a behavioural model.
module tb_windowed_watchdog;

   localparam int CW = 8;
   localparam int RP = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          kick = 1'b0;
   logic [CW-1:0] timeout_val = 8'd20;
   logic [CW-1:0] warn_val = 8'd15;
   logic [CW-1:0] window_open = 8'd5;

   logic          wdt_warn_s [2];
   logic          wdt_reset_s [2];
   logic          cause_timeout_s [2];
   logic          cause_early_s [2];
   logic [7:0]    bite_count_s [2];
   logic [CW-1:0] count_s [2];

   int vectors = 0;
   int miscompares = 0;

   // Model: phase 0 idle, 1 watching, 2 biting
   int m_phase [2];
   int m_elapsed [2];
   int m_rem [2];
   int m_bites [2];
   int m_tmo [2];
   int m_wrn [2];
   int m_win [2];
   bit m_warned [2];
   bit m_ct [2];
   bit m_ce [2];
   bit m_armed [2];

   always #5 clk = ~clk;

   windowed_watchdog #(.CNT_W(CW), .RST_PULSE(RP), .WINDOW_EN(1), .LOCK_EN(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .kick(kick),
      .timeout_val(timeout_val), .warn_val(warn_val), .window_open(window_open),
      .wdt_warn(wdt_warn_s[0]), .wdt_reset(wdt_reset_s[0]),
      .cause_timeout(cause_timeout_s[0]), .cause_early(cause_early_s[0]),
      .bite_count(bite_count_s[0]), .count(count_s[0])
   );

   windowed_watchdog #(.CNT_W(CW), .RST_PULSE(RP), .WINDOW_EN(1), .LOCK_EN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .kick(kick),
      .timeout_val(timeout_val), .warn_val(warn_val), .window_open(window_open),
      .wdt_warn(wdt_warn_s[1]), .wdt_reset(wdt_reset_s[1]),
      .cause_timeout(cause_timeout_s[1]), .cause_early(cause_early_s[1]),
      .bite_count(bite_count_s[1]), .count(count_s[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = 0; m_elapsed[i] = 0; m_rem[i] = 0; m_bites[i] = 0;
         m_tmo[i] = 0; m_wrn[i] = 0; m_win[i] = 0;
         m_warned[i] = 0; m_ct[i] = 0; m_ce[i] = 0; m_armed[i] = 0;
      end
   endtask

   task automatic model_latch(input int i);
      m_tmo[i] = (timeout_val == 8'd0) ? 256 : int'(timeout_val);
      m_wrn[i] = int'(warn_val);
      m_win[i] = int'(window_open);
   endtask

   task automatic model_bite(input int i);
      m_phase[i] = 2;
      m_rem[i] = RP;
      m_bites[i] = (m_bites[i] < 255) ? m_bites[i] + 1 : 255;
      m_elapsed[i] = 0;
      m_warned[i] = 0;
   endtask

   // One rising edge of the reference model, using the inputs the DUT sampled
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit hold;
         hold = enable || ((i == 1) && m_armed[i]);
         case (m_phase[i])
            0: begin
               if (enable) begin
                  m_phase[i] = 1; m_elapsed[i] = 0; m_warned[i] = 0; m_armed[i] = 1;
                  model_latch(i);
               end
            end
            1: begin
               if (!hold) begin
                  m_phase[i] = 0; m_elapsed[i] = 0; m_warned[i] = 0;
               end else if (kick && (m_elapsed[i] < m_win[i])) begin
                  model_bite(i); m_ce[i] = 1;
               end else if (kick) begin
                  m_elapsed[i] = 0; m_warned[i] = 0;
               end else if (m_elapsed[i] + 1 == m_tmo[i]) begin
                  model_bite(i); m_ct[i] = 1;
               end else begin
                  m_elapsed[i]++;
                  if (m_elapsed[i] == m_wrn[i]) m_warned[i] = 1;
               end
            end
            default: begin
               m_rem[i]--;
               if (m_rem[i] == 0) begin
                  if (hold) begin
                     m_phase[i] = 1; m_elapsed[i] = 0; m_warned[i] = 0;
                     model_latch(i);
                  end else begin
                     m_phase[i] = 0;
                  end
               end
            end
         endcase
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("warn[%0d]", i), 32'(wdt_warn_s[i]), 32'((m_phase[i] == 1) && m_warned[i]));
         check($sformatf("reset[%0d]", i), 32'(wdt_reset_s[i]), 32'(m_phase[i] == 2));
         check($sformatf("cause_timeout[%0d]", i), 32'(cause_timeout_s[i]), 32'(m_ct[i]));
         check($sformatf("cause_early[%0d]", i), 32'(cause_early_s[i]), 32'(m_ce[i]));
         check($sformatf("bite_count[%0d]", i), 32'(bite_count_s[i]), 32'(m_bites[i]));
         check($sformatf("count[%0d]", i), 32'(count_s[i]), (m_phase[i] == 1) ? 32'(m_elapsed[i]) : 32'd0);
      end
   endtask

   task automatic clock_only();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic step(input logic en, input logic kk);
      @(negedge clk);
      enable = en;
      kick = kk;
      clock_only();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; enable = 1'b0; kick = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      clock_only();
   endtask

   initial begin
      int peak;
      int rise_at;
      int high_cycles;
      int silent0;
      logic en_r;

      // Reset state
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      clock_only();

      // Regular kicks every 10 cycles never bite or warn
      step(1'b1, 1'b0);
      peak = 0;
      for (int c = 0; c < 100; c++) begin
         step(1'b1, (c % 10) == 9);
         if (int'(count_s[0]) > peak) peak = int'(count_s[0]);
      end
      check("peak_count", 32'(peak), 32'd9);
      check("no_bite_while_kicked", 32'(bite_count_s[0]), 32'd0);

      // Stop kicking: warn, then a 4-cycle bite 20 cycles after the last kick
      rise_at = -1;
      high_cycles = 0;
      for (int n = 1; n <= 30; n++) begin
         step(1'b1, 1'b0);
         if (wdt_reset_s[0]) high_cycles++;
         if (wdt_reset_s[0] && rise_at < 0) rise_at = n;
      end
      check("timeout_latency", 32'(rise_at), 32'd20);
      check("timeout_pulse_len", 32'(high_cycles), 32'd4);

      // Early kick at count 3, kicks during the pulse are ignored
      step(1'b1, 1'b1);
      for (int n = 0; n < 3; n++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("early_bite_now", 32'(wdt_reset_s[0]), 32'd1);
      high_cycles = 1;
      for (int n = 0; n < 3; n++) begin
         step(1'b1, 1'b1);
         if (wdt_reset_s[0]) high_cycles++;
      end
      step(1'b1, 1'b0);
      if (wdt_reset_s[0]) high_cycles++;
      check("early_pulse_len", 32'(high_cycles), 32'd4);
      // Kick at count 5 is legal; kick at count 19 beats the timeout
      for (int n = 0; n < 5; n++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      for (int n = 0; n < 19; n++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("kick_at_19_no_bite", 32'(wdt_reset_s[0]), 32'd0);

      // Enable drop: unlocked goes idle, locked still bites at the old timeout
      timeout_val = 8'd50;
      rise_at = -1;
      silent0 = 0;
      for (int n = 1; n <= 25; n++) begin
         step(1'b0, 1'b0);
         if (wdt_reset_s[1] && rise_at < 0) rise_at = n;
         if (wdt_reset_s[0]) silent0++;
      end
      check("locked_latency", 32'(rise_at), 32'd20);
      check("unlocked_no_bite", 32'(silent0), 32'd0);

      // Asynchronous reset in the middle of a bite
      timeout_val = 8'd20;
      do_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      enable = 1'b0;
      kick = 1'b0;
      clock_only();

      // Zero timeout means 256 cycles
      timeout_val = 8'd0; warn_val = 8'd0; window_open = 8'd0;
      step(1'b1, 1'b0);
      rise_at = -1;
      for (int n = 1; n <= 300 && rise_at < 0; n++) begin
         step(1'b1, 1'b0);
         if (wdt_reset_s[0]) rise_at = n;
      end
      check("zero_timeout_latency", 32'(rise_at), 32'd256);

      // Randomised traffic
      do_reset();
      timeout_val = 8'd20; warn_val = 8'd15; window_open = 8'd5;
      en_r = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 49) == 0) begin
            timeout_val = 8'($urandom_range(8, 40));
            warn_val    = 8'($urandom_range(0, 45));
            window_open = 8'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 59) == 0) en_r = ~en_r;
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            step(en_r, $urandom_range(0, 7) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
